// File: rtl/prog_ctr_pkg.sv
// Shared types and default widths for the fetch-stage program counter.
package prog_ctr_pkg;

  // Run-control states of the program-under-test.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default PC width must equal the branch-target LUT width.
  localparam int PC_W  = 12;
  localparam int CNT_W = 16;

endpackage

// File: rtl/prog_ctr_fsm_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear beats increment; the count sticks at all-ones and never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = (r_cnt == {W{1'b1}});
  assign o_cnt    = r_cnt;

  // Count register: clear, else increment unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/prog_ctr_fsm.sv
// Fetch-stage program counter with start/run/stall/branch/halt/done control
// and a saturating retired-instruction counter.
// Optional macro PC_LINK_EN adds call/ret inputs and a link register.
//
// Handshake: there is no valid/ready pair here; every control input is a
// per-cycle qualifier sampled on the rising edge, and the resulting pc is
// visible in the following cycle (no bubble after a taken branch).
module prog_ctr_fsm
  import prog_ctr_pkg::*;
#(
  parameter int D  = PC_W,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [D-1:0]  start_addr,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [D-1:0]  target,
  input  logic          halt,
`ifdef PC_LINK_EN
  input  logic          call,
  input  logic          ret,
`endif
  output logic [D-1:0]  pc,
  output logic          running,
  output logic          done,
  output logic          pc_wrap,
  output logic [CW-1:0] instr_cnt,
  output state_t        dbg_state
);

  state_t       r_state;
  logic [D-1:0] r_pc;
  logic         r_running;
  logic         r_done;
  logic         r_wrap;
  logic [D-1:0] w_pc_inc;
  logic         w_pc_at_max;
  logic         w_cnt_clr;
  logic         w_cnt_inc;
`ifdef PC_LINK_EN
  logic [D-1:0] r_link;
`endif

  assign w_pc_inc    = r_pc + {{(D-1){1'b0}}, 1'b1};
  assign w_pc_at_max = (r_pc == {D{1'b1}});

  // A start in any state restarts the count; in RUN every non-stalled
  // instruction retires, and halt retires even when stall is also high.
  assign w_cnt_clr = start;
  assign w_cnt_inc = (r_state == RUN) && !start && (halt || !stall);

  // Run-control FSM with registered pc, status flags and link register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
`ifdef PC_LINK_EN
      r_link    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state   <= RUN;
            r_pc      <= start_addr;
            r_wrap    <= 1'b0;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        RUN: begin
          if (start) begin
            r_pc      <= start_addr;
            r_wrap    <= 1'b0;
          end else if (halt) begin
            r_state   <= DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else if (stall) begin
            r_pc      <= r_pc;
`ifdef PC_LINK_EN
          end else if (call) begin
            r_pc      <= target;
            r_link    <= w_pc_inc;
          end else if (ret) begin
            r_pc      <= r_link;
`endif
          end else if (branch_taken) begin
            r_pc      <= target;
          end else begin
            r_pc      <= w_pc_inc;
            if (w_pc_at_max) begin
              r_wrap  <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CW)
  ) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cnt_clr),
    .i_inc (w_cnt_inc),
    .o_cnt (instr_cnt)
  );

  assign pc        = r_pc;
  assign running   = r_running;
  assign done      = r_done;
  assign pc_wrap   = r_wrap;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_prog_ctr_fsm.sv
// Testbench for prog_ctr_fsm: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model. A second instance with a
// 5-bit counter shares the stimulus so saturation is reached quickly.
module tb_prog_ctr_fsm;
  import prog_ctr_pkg::*;

  localparam int D    = 12;
  localparam int N    = 1 << D;
  localparam int CWS  = 5;
  localparam longint MAX_L = 65535;
  localparam longint MAX_S = 31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [D-1:0]  start_addr = '0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [D-1:0]  target = '0;
  logic          halt = 1'b0;
  logic          call = 1'b0;
  logic          ret = 1'b0;

  logic [D-1:0]   pc, pc_s;
  logic           running, running_s, done, done_s, pc_wrap, pc_wrap_s;
  logic [15:0]    instr_cnt;
  logic [CWS-1:0] instr_cnt_s;
  state_t         dbg_state, dbg_state_s;

  prog_ctr_fsm #(.D(D), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .stall(stall), .branch_taken(branch_taken), .target(target), .halt(halt),
`ifdef PC_LINK_EN
    .call(call), .ret(ret),
`endif
    .pc(pc), .running(running), .done(done), .pc_wrap(pc_wrap),
    .instr_cnt(instr_cnt), .dbg_state(dbg_state)
  );

  prog_ctr_fsm #(.D(D), .CW(CWS)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .stall(stall), .branch_taken(branch_taken), .target(target), .halt(halt),
`ifdef PC_LINK_EN
    .call(call), .ret(ret),
`endif
    .pc(pc_s), .running(running_s), .done(done_s), .pc_wrap(pc_wrap_s),
    .instr_cnt(instr_cnt_s), .dbg_state(dbg_state_s)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  // Program state as plain integers; count is unbounded and clipped on read.
  int     m_pc;
  int     m_link;
  bit     m_running, m_done, m_wrap;
  longint m_cnt;

  function automatic void model_reset();
    m_pc = 0; m_link = 0; m_running = 0; m_done = 0; m_wrap = 0; m_cnt = 0;
  endfunction

  function automatic void model_step();
    int nxt;
    if (start) begin
      m_pc = int'(start_addr); m_cnt = 0; m_wrap = 0;
      m_running = 1; m_done = 0;
    end else if (m_running) begin
      if (halt) begin
        m_cnt++; m_running = 0; m_done = 1;
      end else if (stall) begin
        // nothing retires, nothing moves
`ifdef PC_LINK_EN
      end else if (call) begin
        m_link = (m_pc + 1) % N; m_pc = int'(target); m_cnt++;
      end else if (ret) begin
        m_pc = m_link; m_cnt++;
`endif
      end else if (branch_taken) begin
        m_pc = int'(target); m_cnt++;
      end else begin
        nxt = m_pc + 1;
        if (nxt >= N) begin nxt = nxt - N; m_wrap = 1; end
        m_pc = nxt; m_cnt++;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, ".pc"},      32'(pc),        32'(m_pc));
    check_eq({tag, ".running"}, 32'(running),   32'(m_running));
    check_eq({tag, ".done"},    32'(done),      32'(m_done));
    check_eq({tag, ".wrap"},    32'(pc_wrap),   32'(m_wrap));
    check_eq({tag, ".cnt"},     32'(instr_cnt), 32'((m_cnt > MAX_L) ? MAX_L : m_cnt));
    check_eq({tag, ".cnt_s"},   32'(instr_cnt_s), 32'((m_cnt > MAX_S) ? MAX_S : m_cnt));
    check_eq({tag, ".pc_s"},    32'(pc_s),      32'(m_pc));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    start = 0; stall = 0; branch_taken = 0; halt = 0; call = 0; ret = 0;
  endtask

  // One clock: inputs already applied; update the model at the edge and
  // compare 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_start(input int addr);
    start = 1; start_addr = D'(addr);
    tick("start");
  endtask

  task automatic run_plain(input int n);
    for (int i = 0; i < n; i++) tick("plain");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    #12;
    check_eq("reset.pc",      32'(pc),        32'd0);
    check_eq("reset.running", 32'(running),   32'd0);
    check_eq("reset.done",    32'(done),      32'd0);
    check_eq("reset.cnt",     32'(instr_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // IDLE ignores everything but start
    branch_taken = 1; target = 12'd77; halt = 1;
    tick("idle_ignore");

    // start at 0, five sequential instructions
    do_start(0);
    check_eq("start0.running", 32'(running), 32'd1);
    check_eq("start0.pc",      32'(pc),      32'd0);
    run_plain(5);
    check_eq("seq5.pc",  32'(pc),        32'd5);
    check_eq("seq5.cnt", 32'(instr_cnt), 32'd5);

    // branch with stall holds, without stall takes
    do_start(9);
    branch_taken = 1; target = 12'd16; stall = 1;
    tick("br_stall");
    check_eq("br_stall.pc", 32'(pc), 32'd9);
    branch_taken = 1; target = 12'd16;
    tick("br");
    check_eq("br.pc",  32'(pc),        32'd16);
    check_eq("br.cnt", 32'(instr_cnt), 32'd1);

    // halt with stall together: halt wins
    do_start(89);
    halt = 1; stall = 1;
    tick("halt");
    check_eq("halt.done", 32'(done), 32'd1);
    check_eq("halt.pc",   32'(pc),   32'd89);
    check_eq("halt.cnt",  32'(instr_cnt), 32'd1);
    branch_taken = 1; target = 12'd3;
    tick("done_br");
    stall = 1;
    tick("done_stall");
    do_start(0);
    check_eq("restart.done", 32'(done),      32'd0);
    check_eq("restart.cnt",  32'(instr_cnt), 32'd0);

    // wrap from 4095 to 0 is sticky until next start
    do_start(4094);
    run_plain(3);
    check_eq("wrap.pc",   32'(pc),      32'd1);
    check_eq("wrap.flag", 32'(pc_wrap), 32'd1);
    run_plain(2);
    do_start(100);
    check_eq("wrap.clr", 32'(pc_wrap), 32'd0);

    // saturation of the narrow counter
    run_plain(40);
    check_eq("sat.cnt_s", 32'(instr_cnt_s), 32'(MAX_S));

`ifdef PC_LINK_EN
    do_start(20);
    call = 1; target = 12'd60;
    tick("call");
    check_eq("call.pc", 32'(pc), 32'd60);
    run_plain(2);
    ret = 1;
    tick("ret");
    check_eq("ret.pc", 32'(pc), 32'd21);
    call = 1; ret = 1; target = 12'd300;
    tick("call_ret");
    check_eq("call_ret.pc", 32'(pc), 32'd300);
`endif

    // reset asserted between edges mid-RUN
    do_start(45);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_eq("midrst.pc",      32'(pc),        32'd0);
    check_eq("midrst.running", 32'(running),   32'd0);
    check_eq("midrst.cnt",     32'(instr_cnt), 32'd0);
    check_eq("midrst.wrap",    32'(pc_wrap),   32'd0);
    @(negedge clk);
    rst_n = 1;
    tick("post_rst");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      start        = ($urandom_range(0, 99) < 2);
      start_addr   = ($urandom_range(0, 3) == 0) ? D'($urandom_range(N - 6, N - 1))
                                                 : D'($urandom_range(0, N - 1));
      halt         = ($urandom_range(0, 99) < 3);
      stall        = ($urandom_range(0, 99) < 20);
      branch_taken = ($urandom_range(0, 99) < 20);
      target       = D'($urandom_range(0, N - 1));
`ifdef PC_LINK_EN
      call         = ($urandom_range(0, 99) < 8);
      ret          = ($urandom_range(0, 99) < 8);
`endif
      if (!m_running && !m_done && !start && ($urandom_range(0, 1) == 0)) start = 1;
      if (m_done && ($urandom_range(0, 3) == 0)) start = 1;
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: the run is short; anything past this is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
